ex_mem_buf: RTL and testbench

Registered EX→MEM pipeline stage, built as a 2-entry skid FIFO. It captures the write-back triple (waddr, we, wdata) produced by the combinational execute stage. It presents that triple to the memory stage under a valid/ready handshake, so a MEM-side stall never forces a combinational ready path back through EX. It also supports a synchronous flush and optional forwarding lookup for the decode stage.

---
 rtl/ex_mem_buf.sv | 131 +++++++++++++
 tb/tb_ex_mem_buf.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_buf.sv
// ex_mem_buf: registered EX->MEM pipeline stage built as a 2-entry skid FIFO.
// Holds the write-back triple {waddr, we, wdata} under a valid/ready handshake.
// ready_o is a register, so a MEM stall never makes a combinational path into EX.
// Optional macro EX_MEM_FWD_EN adds a combinational forwarding lookup for decode.
module ex_mem_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              we_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              valid_o,
  input  logic              ready_i
`ifdef EX_MEM_FWD_EN
  ,
  input  logic [ADDR_W-1:0] fwd_raddr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_wdata_o
`endif
);

  // Occupancy and ring pointers
  logic [1:0]        r_count;
  logic              r_head;
  logic              r_tail;
  logic              r_ready;
  logic [1:0]        w_count_next;

  // Entry storage
  logic [ADDR_W-1:0] r_waddr [2];
  logic              r_we    [2];
  logic [DATA_W-1:0] r_wdata [2];

  logic w_valid;
  logic w_push;
  logic w_pop;

  assign w_valid = (r_count != 2'd0);
  assign w_push  = valid_i && r_ready;
  assign w_pop   = w_valid && ready_i;

  // Next occupancy from the push/pop pair
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Control state: reset beats flush, flush beats any push/pop this cycle
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_count <= w_count_next;
      r_head  <= r_head ^ w_pop;
      r_tail  <= r_tail ^ w_push;
      // ready_o is precomputed so it only reflects stored state
      r_ready <= (w_count_next != 2'd2);
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      // Entry gi is written when it is the tail slot of an accepted push
      always_ff @(posedge clk) begin
        if (rst) begin
          r_waddr[gi] <= '0;
          r_we[gi]    <= 1'b0;
          r_wdata[gi] <= '0;
        end else if (!flush_i && w_push && (r_tail == 1'(gi))) begin
          r_waddr[gi] <= waddr_i;
          r_we[gi]    <= we_i;
          r_wdata[gi] <= wdata_i;
        end
      end
    end
  endgenerate

  // Head outputs are gated to zero when empty rather than showing stale data
  assign ready_o = r_ready;
  assign valid_o = w_valid;
  assign waddr_o = w_valid ? r_waddr[r_head] : '0;
  assign we_o    = w_valid ? r_we[r_head]    : 1'b0;
  assign wdata_o = w_valid ? r_wdata[r_head] : '0;

`ifdef EX_MEM_FWD_EN
  logic [1:0] w_match;
  logic       w_young;

  // The most recently written slot sits just behind the tail pointer
  assign w_young = ~r_tail;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic w_live;
      // Slot is live when the FIFO is full, or it is the head of a 1-deep FIFO
      assign w_live = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'(gi)));
      assign w_match[gi] = w_live && r_we[gi] && (r_waddr[gi] == fwd_raddr_i)
                           && (fwd_raddr_i != '0);
    end
  endgenerate

  // Younger match takes precedence over the older head entry
  always_comb begin
    fwd_hit_o   = 1'b0;
    fwd_wdata_o = '0;
    if (w_match[w_young]) begin
      fwd_hit_o   = 1'b1;
      fwd_wdata_o = r_wdata[w_young];
    end else if (w_match[~w_young]) begin
      fwd_hit_o   = 1'b1;
      fwd_wdata_o = r_wdata[~w_young];
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_buf.sv
// Directed testbench for ex_mem_buf (forwarding tests built only with EX_MEM_FWD_EN).
module tb_ex_mem_buf;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  waddr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [4:0]  waddr_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic        valid_o;
  logic        ready_i;
`ifdef EX_MEM_FWD_EN
  logic [4:0]  fwd_raddr_i;
  logic        fwd_hit_o;
  logic [31:0] fwd_wdata_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Observed head as {valid, waddr, we, wdata}
  logic [38:0] w_obs;
  assign w_obs = {valid_o, waddr_o, we_o, wdata_o};

  always #5 clk = ~clk;

  ex_mem_buf #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i), .valid_i(valid_i),
    .ready_o(ready_o), .flush_i(flush_i),
    .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o), .valid_o(valid_o),
    .ready_i(ready_i)
`ifdef EX_MEM_FWD_EN
    , .fwd_raddr_i(fwd_raddr_i), .fwd_hit_o(fwd_hit_o), .fwd_wdata_o(fwd_wdata_o)
`endif
  );

  // Advance past the next rising edge before touching inputs
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic w, input logic [31:0] d);
    valid_i = v; waddr_i = a; we_i = w; wdata_i = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 32'h99);
    tick; tick;
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready: got %b expected 1", ready_o);
    end
    n_checks++;
    if (w_obs !== 39'h0) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected %h", w_obs, 39'h0);
    end
    rst = 1'b0;
    tick;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (w_obs !== {1'b1, 5'd1, 1'b1, 32'h99}) begin
      n_errors++; $display("FAIL reset_first_push: got %h expected %h", w_obs, {1'b1, 5'd1, 1'b1, 32'h99});
    end
    ready_i = 1'b1;
    tick;
    ready_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (w_obs !== 39'h0) begin
      n_errors++; $display("FAIL reset_drain_empty: got %h expected %h", w_obs, 39'h0);
    end
    $display("test_reset done: checks=%0d errors=%0d", n_checks, n_errors);
  endtask

  task automatic test_streaming;
    ready_i = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 32'h11);
    tick;
    drive(1'b1, 5'd4, 1'b1, 32'h22);
    @(negedge clk);
    n_checks++;
    if ({ready_o, w_obs} !== {1'b1, 1'b1, 5'd3, 1'b1, 32'h11}) begin
      n_errors++; $display("FAIL stream_a: got %h expected %h", {ready_o, w_obs}, {1'b1, 1'b1, 5'd3, 1'b1, 32'h11});
    end
    tick;
    drive(1'b1, 5'd5, 1'b0, 32'h33);
    @(negedge clk);
    n_checks++;
    if ({ready_o, w_obs} !== {1'b1, 1'b1, 5'd4, 1'b1, 32'h22}) begin
      n_errors++; $display("FAIL stream_b: got %h expected %h", {ready_o, w_obs}, {1'b1, 1'b1, 5'd4, 1'b1, 32'h22});
    end
    tick;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({ready_o, w_obs} !== {1'b1, 1'b1, 5'd5, 1'b0, 32'h33}) begin
      n_errors++; $display("FAIL stream_c_bubble: got %h expected %h", {ready_o, w_obs}, {1'b1, 1'b1, 5'd5, 1'b0, 32'h33});
    end
    tick;
    @(negedge clk);
    n_checks++;
    if (w_obs !== 39'h0) begin
      n_errors++; $display("FAIL stream_empty: got %h expected %h", w_obs, 39'h0);
    end
    ready_i = 1'b0;
    $display("test_streaming done: checks=%0d errors=%0d", n_checks, n_errors);
  endtask

  task automatic test_backpressure;
    ready_i = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 32'hA);
    tick;
    drive(1'b1, 5'd8, 1'b1, 32'hB);
    @(negedge clk);
    n_checks++;
    if ({ready_o, w_obs} !== {1'b1, 1'b1, 5'd7, 1'b1, 32'hA}) begin
      n_errors++; $display("FAIL bp_one_entry: got %h expected %h", {ready_o, w_obs}, {1'b1, 1'b1, 5'd7, 1'b1, 32'hA});
    end
    tick;
    drive(1'b1, 5'd9, 1'b1, 32'hC);
    @(negedge clk);
    n_checks++;
    if ({ready_o, w_obs} !== {1'b0, 1'b1, 5'd7, 1'b1, 32'hA}) begin
      n_errors++; $display("FAIL bp_full: got %h expected %h", {ready_o, w_obs}, {1'b0, 1'b1, 5'd7, 1'b1, 32'hA});
    end
    tick;  // third value held off, head stable
    @(negedge clk);
    n_checks++;
    if ({ready_o, w_obs} !== {1'b0, 1'b1, 5'd7, 1'b1, 32'hA}) begin
      n_errors++; $display("FAIL bp_hold: got %h expected %h", {ready_o, w_obs}, {1'b0, 1'b1, 5'd7, 1'b1, 32'hA});
    end
    ready_i = 1'b1;
    tick;  // pop A, push still blocked this edge
    @(negedge clk);
    n_checks++;
    if ({ready_o, w_obs} !== {1'b1, 1'b1, 5'd8, 1'b1, 32'hB}) begin
      n_errors++; $display("FAIL bp_drain_b: got %h expected %h", {ready_o, w_obs}, {1'b1, 1'b1, 5'd8, 1'b1, 32'hB});
    end
    tick;  // pop B, push C
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({ready_o, w_obs} !== {1'b1, 1'b1, 5'd9, 1'b1, 32'hC}) begin
      n_errors++; $display("FAIL bp_drain_c: got %h expected %h", {ready_o, w_obs}, {1'b1, 1'b1, 5'd9, 1'b1, 32'hC});
    end
    tick;
    @(negedge clk);
    n_checks++;
    if (w_obs !== 39'h0) begin
      n_errors++; $display("FAIL bp_empty: got %h expected %h", w_obs, 39'h0);
    end
    ready_i = 1'b0;
    $display("test_backpressure done: checks=%0d errors=%0d", n_checks, n_errors);
  endtask

  task automatic test_flush;
    ready_i = 1'b0;
    drive(1'b1, 5'd10, 1'b1, 32'h1);
    tick;
    drive(1'b1, 5'd11, 1'b1, 32'h2);
    tick;
    flush_i = 1'b1; ready_i = 1'b1;
    drive(1'b1, 5'd12, 1'b1, 32'h3);
    tick;
    flush_i = 1'b0; ready_i = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({ready_o, w_obs} !== {1'b1, 39'h0}) begin
      n_errors++; $display("FAIL flush_full: got %h expected %h", {ready_o, w_obs}, {1'b1, 39'h0});
    end
    // One entry buffered so the concurrent push would otherwise be accepted
    drive(1'b1, 5'd13, 1'b1, 32'h4);
    tick;
    flush_i = 1'b1;
    drive(1'b1, 5'd14, 1'b1, 32'h5);
    tick;
    flush_i = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({ready_o, w_obs} !== {1'b1, 39'h0}) begin
      n_errors++; $display("FAIL flush_push_dropped: got %h expected %h", {ready_o, w_obs}, {1'b1, 39'h0});
    end
    // Reset mid-stream behaves like flush
    drive(1'b1, 5'd15, 1'b1, 32'h6);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({ready_o, w_obs} !== {1'b1, 39'h0}) begin
      n_errors++; $display("FAIL reset_midstream: got %h expected %h", {ready_o, w_obs}, {1'b1, 39'h0});
    end
    $display("test_flush done: checks=%0d errors=%0d", n_checks, n_errors);
  endtask

`ifdef EX_MEM_FWD_EN
  task automatic test_forwarding;
    ready_i = 1'b0;
    fwd_raddr_i = 5'd9;
    drive(1'b1, 5'd9, 1'b1, 32'h100);
    tick;
    drive(1'b1, 5'd9, 1'b1, 32'h200);
    tick;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({fwd_hit_o, fwd_wdata_o} !== {1'b1, 32'h200}) begin
      n_errors++; $display("FAIL fwd_younger: got %b/%h expected 1/%h", fwd_hit_o, fwd_wdata_o, 32'h200);
    end
    flush_i = 1'b1; tick; flush_i = 1'b0;
    drive(1'b1, 5'd13, 1'b1, 32'h55);
    tick;
    drive(1'b1, 5'd14, 1'b1, 32'h66);
    tick;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    fwd_raddr_i = 5'd13;
    @(negedge clk);
    n_checks++;
    if ({fwd_hit_o, fwd_wdata_o} !== {1'b1, 32'h55}) begin
      n_errors++; $display("FAIL fwd_older: got %b/%h expected 1/%h", fwd_hit_o, fwd_wdata_o, 32'h55);
    end
    flush_i = 1'b1; tick; flush_i = 1'b0;
    drive(1'b1, 5'd0, 1'b1, 32'h5);
    tick;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    fwd_raddr_i = 5'd0;
    @(negedge clk);
    n_checks++;
    if ({fwd_hit_o, fwd_wdata_o} !== {1'b0, 32'h0}) begin
      n_errors++; $display("FAIL fwd_zero_addr: got %b/%h expected 0/0", fwd_hit_o, fwd_wdata_o);
    end
    flush_i = 1'b1; tick; flush_i = 1'b0;
    drive(1'b1, 5'd6, 1'b0, 32'h7);
    tick;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    fwd_raddr_i = 5'd6;
    @(negedge clk);
    n_checks++;
    if ({fwd_hit_o, fwd_wdata_o} !== {1'b0, 32'h0}) begin
      n_errors++; $display("FAIL fwd_no_we: got %b/%h expected 0/0", fwd_hit_o, fwd_wdata_o);
    end
    flush_i = 1'b1; tick; flush_i = 1'b0;
    $display("test_forwarding done: checks=%0d errors=%0d", n_checks, n_errors);
  endtask
`endif

  initial begin
`ifdef EX_MEM_FWD_EN
    fwd_raddr_i = 5'd0;
`endif
    test_reset;
    test_streaming;
    test_backpressure;
    test_flush;
`ifdef EX_MEM_FWD_EN
    test_forwarding;
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
